uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_FREQ SHALL be defined as: default 50_000_000; input clock frequency in Hz.
REQ-002 Parameter BAUD SHALL be defined as: default 115_200; line bit rate in bit/s.
REQ-003 Derived constant CLKS_PER_BIT SHALL be CLK_FREQ/BAUD (integer, truncated); values below 2 are unsupported.
REQ-004 Port RST_clk SHALL be: input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 Port RST SHALL be: input, 1 bit, synchronous active-high reset.
REQ-006 Port tx_start SHALL be: input, 1 bit, request to send tx_data.
REQ-007 Port tx_data SHALL be: input, 8 bits, byte to send, sampled only when a request is accepted.
REQ-008 Port uart_tx_data SHALL be: output, 1 bit, serial line, idle high.
REQ-009 Port tx_busy SHALL be: output, 1 bit, high while a frame is in progress.
REQ-010 Port tx_done SHALL be: output, 1 bit, single-cycle pulse when a frame completes.

Function
REQ-011 The frame SHALL be: 1 start bit (0), 8 data bits LSB first, optional parity bit (REQ-030), 1 stop bit (1).
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is reachable only when parity is compiled in.
REQ-013 In IDLE, when tx_start=1 in cycle N, tx_data SHALL be latched into an internal shift register, the FSM goes to START, and tx_busy=1 and uart_tx_data=0 from cycle N+1.
REQ-014 Every bit SHALL be driven for exactly CLKS_PER_BIT cycles, counted by a baud counter that clears on every state change.
REQ-015 DATA SHALL shift out bits 0..7 using a 3-bit bit index; after bit 7's period it goes to PARITY (if compiled in) or STOP.
REQ-016 After STOP's period the FSM SHALL return to IDLE; in that first IDLE cycle tx_busy=0, tx_done=1 for exactly one cycle, and uart_tx_data=1.
REQ-017 tx_start asserted while tx_busy=1 SHALL be ignored; it is not queued, and the frame and latched data are unaffected.
REQ-018 tx_start asserted in the same cycle as tx_done=1 SHALL be accepted (back-to-back), giving stop-to-start spacing of exactly one stop-bit period plus one cycle.
REQ-019 Changes on tx_data after acceptance SHALL NOT affect the frame in progress.
REQ-020 uart_tx_data SHALL be driven from a register (glitch-free, no combinational path from inputs).
REQ-021 Total cycles from the acceptance cycle to the tx_done cycle SHALL be 10*CLKS_PER_BIT without parity and 11*CLKS_PER_BIT with parity.

Reset
REQ-022 While RST=1 at a rising edge, the FSM SHALL enter IDLE and the baud counter, bit index and shift register SHALL clear to 0.
REQ-023 Reset values SHALL be: uart_tx_data=1, tx_busy=0, tx_done=0.
REQ-024 Reset mid-frame SHALL abort the frame: the line goes high on the next cycle and no tx_done pulse is produced.
REQ-025 tx_start asserted in the same cycle as RST=1 SHALL be ignored.
REQ-026 The block SHALL NOT use initial statements for functional state.

Configuration
REQ-030 Macro UART_TX_PARITY_EN SHALL control the parity bit.
- Defined: one even-parity bit (XOR of the 8 latched data bits) is sent after bit 7, lasting CLKS_PER_BIT cycles.
- Undefined: PARITY state and parity logic are absent; DATA goes directly to STOP.

Verification
Bench SHALL use CLK_FREQ=1_600_000, BAUD=100_000 (CLKS_PER_BIT=16).
REQ-040 Reset, then idle for 50 cycles -> uart_tx_data=1, tx_busy=0, tx_done=0 throughout.
REQ-041 Send tx_data=0x55 with a 1-cycle tx_start -> line sequence 0,1,0,1,0,1,0,1,0,1, each level held 16 cycles; tx_done pulses exactly 160 cycles after acceptance (176 with parity; parity bit = 0).
REQ-042 Send 0xA3, then pulse tx_start with 0xFF at cycle 40 of the frame -> frame carries 0xA3 only; no second frame starts.
REQ-043 Send 0x01 with tx_start held high continuously -> frames back-to-back; the second start bit begins the cycle after tx_done; each frame carries 0x01.
REQ-044 Assert RST during bit 3 of 0x00 -> line high the next cycle, tx_busy=0, no tx_done; a following send of 0x80 is correct.
REQ-045 With UART_TX_PARITY_EN defined, send 0x07 -> parity bit = 1.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 framing (8E1 when UART_TX_PARITY_EN is defined),
// LSB first, line idle high, one frame per accepted tx_start.
//
// Parameters:
//   CLK_FREQ  input clock frequency in Hz
//   BAUD      line bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD must be >= 2
// Ports:
//   RST_clk       single clock, rising edge
//   RST           synchronous active-high reset
//   tx_start      send request, honoured only while idle
//   tx_data       byte to send, sampled when a request is accepted
//   uart_tx_data  registered serial line output, idle high
//   tx_busy       high while a frame is in progress
//   tx_done       one-cycle pulse in the first idle cycle after a frame
// Build option:
//   UART_TX_PARITY_EN  adds an even-parity bit after data bit 7

module uart_tx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       RST_clk,
    input  logic       RST,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       uart_tx_data,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_end;

    // Last cycle of the current bit period.
    assign bit_end = (baud_cnt == CNT_MAX);

    // The line level for the next bit is registered on the same edge that
    // changes state, so every level lasts exactly CLKS_PER_BIT cycles.
    always_ff @(posedge RST_clk) begin
        if (RST) begin
            state        <= IDLE;
            baud_cnt     <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            uart_tx_data <= 1'b1;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (tx_start) begin
                        shreg        <= tx_data;
                        state        <= START;
                        tx_busy      <= 1'b1;
                        uart_tx_data <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt     <= '0;
                        bit_idx      <= '0;
                        state        <= DATA;
                        uart_tx_data <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state        <= PARITY;
                            uart_tx_data <= ^shreg;
`else
                            state        <= STOP;
                            uart_tx_data <= 1'b1;
`endif
                        end else begin
                            bit_idx      <= bit_idx + 3'd1;
                            uart_tx_data <= shreg[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        baud_cnt     <= '0;
                        state        <= STOP;
                        uart_tx_data <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        baud_cnt     <= '0;
                        state        <= IDLE;
                        uart_tx_data <= 1'b1;
                        tx_busy      <= 1'b0;
                        tx_done      <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    baud_cnt     <= '0;
                    state        <= IDLE;
                    uart_tx_data <= 1'b1;
                    tx_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx at CLKS_PER_BIT = 16.
// Follows UART_TX_PARITY_EN the same way as the design.

module tb_uart_tx;

    localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       line;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx #(
        .CLK_FREQ(1_600_000),
        .BAUD    (100_000)
    ) dut (
        .RST_clk     (clk),
        .RST         (rst),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .uart_tx_data(line),
        .tx_busy     (busy),
        .tx_done     (done)
    );

    // Expected line level for bit slot idx of a frame carrying d.
    function automatic logic frame_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        tx_start = 1'b1;
        tx_data  = 8'hFF;
        tick;
        tick;
        checks++;
        if (line !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state line=%b busy=%b done=%b exp 1 0 0",
                     line, busy, done);
        end
        rst      = 1'b0;
        tx_start = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick;
            checks++;
            if (line !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle k=%0d line=%b busy=%b done=%b exp 1 0 0",
                         k, line, busy, done);
            end
        end
    endtask

    task automatic test_frame_55;
        logic [7:0] d;
        d        = 8'h55;
        tx_data  = d;
        tx_start = 1'b1;
        tick;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        for (int k = 0; k < NB * CPB; k++) begin
            checks++;
            if (line !== frame_bit(d, k / CPB) || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL frame55 k=%0d line=%b busy=%b done=%b exp %b 1 0",
                         k, line, busy, done, frame_bit(d, k / CPB));
            end
            tick;
        end
        checks++;
        if (line !== 1'b1 || busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL frame55_done line=%b busy=%b done=%b exp 1 0 1",
                     line, busy, done);
        end
        tick;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL frame55_pulse done=%b busy=%b exp 0 0", done, busy);
        end
    endtask

    task automatic test_ignore_busy;
        logic [7:0] d;
        d        = 8'hA3;
        tx_data  = d;
        tx_start = 1'b1;
        tick;
        tx_start = 1'b0;
        for (int k = 0; k < NB * CPB; k++) begin
            checks++;
            if (line !== frame_bit(d, k / CPB) || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL ignore_busy k=%0d line=%b busy=%b done=%b exp %b 1 0",
                         k, line, busy, done, frame_bit(d, k / CPB));
            end
            if (k == 40) begin
                tx_start = 1'b1;
                tx_data  = 8'hFF;
            end else begin
                tx_start = 1'b0;
            end
            tick;
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_busy_done done=%b busy=%b exp 1 0", done, busy);
        end
        for (int k = 0; k < 3 * CPB; k++) begin
            tick;
            checks++;
            if (line !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL ignore_busy_idle k=%0d line=%b busy=%b done=%b exp 1 0 0",
                         k, line, busy, done);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d;
        d        = 8'h01;
        tx_data  = d;
        tx_start = 1'b1;
        tick;
        for (int f = 0; f < 2; f++) begin
            if (f == 1) tx_start = 1'b0;
            for (int k = 0; k < NB * CPB; k++) begin
                checks++;
                if (line !== frame_bit(d, k / CPB) || busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b f=%0d k=%0d line=%b busy=%b done=%b exp %b 1 0",
                             f, k, line, busy, done, frame_bit(d, k / CPB));
                end
                tick;
            end
            checks++;
            if (line !== 1'b1 || busy !== 1'b0 || done !== 1'b1) begin
                errors++;
                $display("FAIL b2b_done f=%0d line=%b busy=%b done=%b exp 1 0 1",
                         f, line, busy, done);
            end
            tick;
        end
        checks++;
        if (line !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end line=%b busy=%b done=%b exp 1 0 0",
                     line, busy, done);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] d;
        tx_data  = 8'h00;
        tx_start = 1'b1;
        tick;
        tx_start = 1'b0;
        for (int k = 0; k < 70; k++) begin
            checks++;
            if (line !== frame_bit(8'h00, k / CPB)) begin
                errors++;
                $display("FAIL abort_pre k=%0d line=%b exp %b",
                         k, line, frame_bit(8'h00, k / CPB));
            end
            tick;
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if (line !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset line=%b busy=%b done=%b exp 1 0 0",
                     line, busy, done);
        end
        for (int k = 0; k < NB * CPB + 20; k++) begin
            tick;
            checks++;
            if (line !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL abort_idle k=%0d line=%b busy=%b done=%b exp 1 0 0",
                         k, line, busy, done);
            end
        end
        d        = 8'h80;
        tx_data  = d;
        tx_start = 1'b1;
        tick;
        tx_start = 1'b0;
        for (int k = 0; k < NB * CPB; k++) begin
            checks++;
            if (line !== frame_bit(d, k / CPB) || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL after_abort k=%0d line=%b busy=%b done=%b exp %b 1 0",
                         k, line, busy, done, frame_bit(d, k / CPB));
            end
            tick;
        end
        checks++;
        if (line !== 1'b1 || busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL after_abort_done line=%b busy=%b done=%b exp 1 0 1",
                     line, busy, done);
        end
        tick;
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        logic [7:0] d;
        d        = 8'h07;
        tx_data  = d;
        tx_start = 1'b1;
        tick;
        tx_start = 1'b0;
        for (int k = 0; k < NB * CPB; k++) begin
            checks++;
            if (line !== frame_bit(d, k / CPB)) begin
                errors++;
                $display("FAIL parity_frame k=%0d line=%b exp %b",
                         k, line, frame_bit(d, k / CPB));
            end
            if (k == 9 * CPB + 8) begin
                checks++;
                if (line !== 1'b1) begin
                    errors++;
                    $display("FAIL parity_bit line=%b exp 1", line);
                end
            end
            tick;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL parity_done done=%b exp 1", done);
        end
        tick;
    endtask
`endif

    initial begin
        rst      = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        test_reset;
        test_frame_55;
        test_ignore_busy;
        test_back_to_back;
        test_reset_mid_frame;
`ifdef UART_TX_PARITY_EN
        test_parity;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
